add_reservation_unit: RTL and testbench

- Adder/subtractor functional unit on the responder side of the ADD dispatch interface driven by the issue/Tomasulo top module.
- Accepts one dispatched operation (tag, two 8-bit operands, add/sub select) when not busy, and executes it over LATENCY cycles.
- Arbitrates for the common data bus (CDB) with a request/grant handshake, then broadcasts the tag and result for one cycle.
- Drives the busy status that the dispatcher samples before issuing.

---
 rtl/add_reservation_unit.sv | 153 +++++++++++++++
 tb/tb_add_reservation_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_reservation_unit.sv
// add_reservation_unit
//   Adder/subtractor functional unit sitting behind the ADD dispatch port.
//   Accepts one operation when not busy, executes it for LATENCY cycles,
//   requests the common data bus, and broadcasts tag+result for one cycle
//   once granted.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   issue_valid/tag/op1/op2/sub : dispatched operation (sub=1 -> op1-op2)
//   flush             : squash the in-flight operation
//   add_busy          : unit cannot accept an issue this cycle
//   cdb_req/cdb_grant : CDB request/grant handshake
//   cdb_valid/tag/data: one-cycle CDB broadcast; tag/data hold between strobes
//   bad_issue         : sticky flag, an issue with tag 0 was attempted
module add_reservation_unit #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [DATA_W-1:0] issue_op1,
  input  logic [DATA_W-1:0] issue_op2,
  input  logic              issue_sub,
  input  logic              flush,
  output logic              add_busy,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              bad_issue
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT_CDB,
    S_BCAST
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic              sub_q, sub_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              bad_issue_q, bad_issue_d;

  logic [DATA_W-1:0] alu_out;
  logic              can_issue;

  // Two's complement subtract; carry/borrow out is dropped by the width.
  always_comb begin
    if (sub_q) alu_out = op1_q + ~op2_q + DATA_W'(1);
    else       alu_out = op1_q + op2_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tag_d       = tag_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    sub_d       = sub_q;
    result_d    = result_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    bad_issue_d = bad_issue_q;
    can_issue   = (state_q == S_IDLE) || (state_q == S_BCAST);

    case (state_q)
      S_IDLE: ;
      S_EXEC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          result_d = alu_out;
          state_d  = S_WAIT_CDB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WAIT_CDB: begin
        // flush wins over a simultaneous grant: nothing is broadcast.
        if (flush) begin
          state_d = S_IDLE;
        end else if (cdb_grant) begin
          state_d    = S_BCAST;
          cdb_tag_d  = tag_q;
          cdb_data_d = result_q;
        end
      end
      S_BCAST: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Issue acceptance overrides the BCAST->IDLE return for back-to-back ops.
    if (can_issue && issue_valid) begin
      if (issue_tag == '0) begin
        bad_issue_d = 1'b1;
      end else if (!flush) begin
        tag_d   = issue_tag;
        op1_d   = issue_op1;
        op2_d   = issue_op2;
        sub_d   = issue_sub;
        cnt_d   = CNT_INIT;
        state_d = S_EXEC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tag_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      sub_q       <= 1'b0;
      result_q    <= '0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      bad_issue_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      sub_q       <= sub_d;
      result_q    <= result_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      bad_issue_q <= bad_issue_d;
    end
  end

  assign add_busy  = (state_q == S_EXEC) || (state_q == S_WAIT_CDB);
  assign cdb_req   = (state_q == S_WAIT_CDB);
  assign cdb_valid = (state_q == S_BCAST);
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign bad_issue = bad_issue_q;

endmodule

// File: tb/tb_add_reservation_unit.sv
module tb_add_reservation_unit;
  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0;
  logic [2:0] issue_tag = '0;
  logic [7:0] issue_op1 = '0;
  logic [7:0] issue_op2 = '0;
  logic       issue_sub = 1'b0;
  logic       flush = 1'b0;
  logic       cdb_grant = 1'b0;
  logic       add_busy, cdb_req, cdb_valid, bad_issue;
  logic [2:0] cdb_tag;
  logic [7:0] cdb_data;

  int checks = 0;
  int errors = 0;

  // Reference model: an accepted operation ages one step per edge; it may
  // use the bus once it is LAT edges old, and its result is fixed at issue.
  bit m_op;
  int m_age, m_tag, m_res;
  bit m_bcast;
  int m_ctag, m_cdata;
  bit m_bad;

  always #5 clk = ~clk;

  add_reservation_unit #(.LATENCY(LAT), .TAG_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_tag(issue_tag),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_sub(issue_sub),
    .flush(flush), .add_busy(add_busy), .cdb_req(cdb_req),
    .cdb_grant(cdb_grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .bad_issue(bad_issue)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit was_free;
    was_free = !m_op;
    m_bcast = 1'b0;
    if (rst) begin
      m_op = 0; m_age = 0; m_ctag = 0; m_cdata = 0; m_bad = 0;
      return;
    end
    if (m_op) begin
      if (flush) m_op = 0;
      else if (m_age >= LAT && cdb_grant) begin
        m_op = 0; m_bcast = 1; m_ctag = m_tag; m_cdata = m_res;
      end else if (m_age < LAT) m_age++;
    end
    if (was_free && issue_valid) begin
      if (issue_tag == 0) m_bad = 1;
      else if (!flush) begin
        m_op = 1; m_age = 0; m_tag = int'(issue_tag);
        if (issue_sub) m_res = (int'(issue_op1) - int'(issue_op2) + 256) % 256;
        else           m_res = (int'(issue_op1) + int'(issue_op2)) % 256;
      end
    end
  endtask

  task automatic check_outputs();
    chk("add_busy", add_busy, m_op);
    chk("cdb_req", cdb_req, m_op && m_age >= LAT);
    chk("cdb_valid", cdb_valid, m_bcast);
    chk("cdb_tag", cdb_tag, m_ctag);
    chk("cdb_data", cdb_data, m_cdata);
    chk("bad_issue", bad_issue, m_bad);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic issue(input int tag, input int a, input int b, input bit s);
    issue_valid = 1'b1;
    issue_tag   = 3'(tag);
    issue_op1   = 8'(a);
    issue_op2   = 8'(b);
    issue_sub   = s;
  endtask

  task automatic wait_valid(input string name, input int max_cyc);
    int n;
    n = 0;
    while (cdb_valid !== 1'b1 && n < max_cyc) begin
      cyc();
      n++;
    end
    chk(name, cdb_valid, 1'b1);
  endtask

  initial begin
    // Reset
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Basic add with grant tied high
    cdb_grant = 1'b1;
    issue(3, 8'h25, 8'h17, 1'b0);
    cyc();                                    // edge N
    issue_valid = 1'b0;
    chk("basic_busy_N", add_busy, 1'b1);
    cyc();                                    // N+1
    chk("basic_req_N1", cdb_req, 1'b0);
    cyc();                                    // N+2
    chk("basic_req_N2", cdb_req, 1'b1);
    chk("basic_busy_N2", add_busy, 1'b1);
    cyc();                                    // N+3
    chk("basic_valid", cdb_valid, 1'b1);
    chk("basic_tag", cdb_tag, 3'd3);
    chk("basic_data", cdb_data, 8'h3C);
    cyc();
    chk("basic_valid_once", cdb_valid, 1'b0);

    // Wrap and subtract
    issue(1, 8'hF0, 8'h20, 1'b0);
    cyc(); issue_valid = 1'b0;
    wait_valid("wrap_timeout", 20);
    chk("wrap_data", cdb_data, 8'h10);
    issue(2, 8'h05, 8'h07, 1'b1);
    cyc(); issue_valid = 1'b0;
    wait_valid("sub_timeout", 20);
    chk("sub_data", cdb_data, 8'hFE);
    cyc();

    // Grant stall
    cdb_grant = 1'b0;
    issue(4, 8'h80, 8'h80, 1'b0);
    cyc(); issue_valid = 1'b0;
    for (int i = 0; i < 20 && cdb_req !== 1'b1; i++) cyc();
    chk("stall_req_seen", cdb_req, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_req", cdb_req, 1'b1);
      chk("stall_busy", add_busy, 1'b1);
      chk("stall_valid", cdb_valid, 1'b0);
    end
    cdb_grant = 1'b1;
    cyc();
    chk("stall_bcast", cdb_valid, 1'b1);
    chk("stall_data", cdb_data, 8'h00);
    cyc();
    chk("stall_single", cdb_valid, 1'b0);

    // Back-to-back: tag 5 issued during BCAST of tag 2
    issue(2, 8'h11, 8'h22, 1'b0);
    cyc(); issue_valid = 1'b0;
    wait_valid("b2b_first_timeout", 20);
    chk("b2b_first_tag", cdb_tag, 3'd2);
    chk("b2b_bcast_not_busy", add_busy, 1'b0);
    issue(5, 8'h40, 8'h01, 1'b1);
    cyc(); issue_valid = 1'b0;
    chk("b2b_accept", add_busy, 1'b1);
    for (int i = 0; i < LAT; i++) cyc();
    cyc();
    chk("b2b_second_valid", cdb_valid, 1'b1);
    chk("b2b_second_tag", cdb_tag, 3'd5);
    chk("b2b_second_data", cdb_data, 8'h3F);
    cyc();

    // Flush in EXEC, flush with issue in IDLE
    issue(6, 8'h01, 8'h01, 1'b0);
    cyc(); issue_valid = 1'b0;
    flush = 1'b1;
    cyc();
    chk("flush_busy", add_busy, 1'b0);
    issue(1, 8'h01, 8'h01, 1'b0);
    cyc(); issue_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_issue", add_busy, 1'b0);
    for (int i = 0; i < 10; i++) cyc();

    // Bad tag
    issue(0, 8'h12, 8'h34, 1'b0);
    cyc(); issue_valid = 1'b0;
    chk("bad_set", bad_issue, 1'b1);
    chk("bad_not_accepted", add_busy, 1'b0);
    for (int i = 0; i < 4; i++) cyc();
    chk("bad_sticky", bad_issue, 1'b1);

    // Reset mid-EXEC
    issue(7, 8'h09, 8'h09, 1'b0);
    cyc(); issue_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_busy", add_busy, 1'b0);
    chk("rst_bad", bad_issue, 1'b0);
    chk("rst_tag", cdb_tag, 3'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("rst_no_valid", cdb_valid, 1'b0);
    end

    // Randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_tag   = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      issue_op1   = 8'($urandom);
      issue_op2   = 8'($urandom);
      issue_sub   = 1'($urandom);
      cdb_grant   = ($urandom_range(0, 9) < 6);
      flush       = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 99) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
